// File: rtl/ultra_sonic_echo_model.sv
// HC-SR04-style ultrasonic sensor emulator: accepts a trigger pulse and answers
// with an echo pulse whose width is loaded through a simple write port.
module ultra_sonic_echo_model #(
   parameter int unsigned MIN_TRIG_CYCLES    = 500,
   parameter int unsigned BURST_DELAY_CYCLES = 23000,
   parameter int unsigned HOLDOFF_CYCLES     = 3000,
   parameter int unsigned TIMEOUT_CYCLES     = 1900000
) (
   input  logic        clk,
   input  logic        reset_l,
   input  logic        trigger,
   input  logic        write,
   input  logic [31:0] write_data,
   output logic        echo,
   output logic        busy,
   output logic [31:0] read_data
);

   localparam logic [31:0] MIN_W     = 32'(MIN_TRIG_CYCLES);
   localparam logic [31:0] BURST_W   = 32'(BURST_DELAY_CYCLES);
   localparam logic [31:0] HOLDOFF_W = 32'(HOLDOFF_CYCLES);
   localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      TRIG_HIGH,
      DELAY,
      ECHO,
      HOLDOFF
   } state_t;

   state_t      state;
   logic        sync1;
   logic        trig_s;
   logic        trig_prev;
   logic [31:0] trig_cnt;
   logic [31:0] cnt;
   logic [31:0] echo_len;
   logic [31:0] width_reg;
   logic [15:0] pulse_count;

   // trig_prev tracks trig_s in every state so a trigger held high across
   // HOLDOFF->IDLE is not mistaken for a fresh rising edge.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         sync1     <= 1'b0;
         trig_s    <= 1'b0;
         trig_prev <= 1'b0;
      end else begin
         sync1     <= trigger;
         trig_s    <= sync1;
         trig_prev <= trig_s;
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         width_reg <= '0;
      end else if (write) begin
         width_reg <= write_data;
      end
   end

   // One shared down-counter times DELAY, ECHO and HOLDOFF; each phase ends
   // on the cycle the counter reads 1.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state       <= IDLE;
         echo        <= 1'b0;
         trig_cnt    <= '0;
         cnt         <= '0;
         echo_len    <= '0;
         pulse_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               echo <= 1'b0;
               if (trig_s && !trig_prev) begin
                  state    <= TRIG_HIGH;
                  trig_cnt <= 32'd1;
               end
            end
            TRIG_HIGH: begin
               if (trig_s) begin
                  if (trig_cnt < MIN_W) begin
                     trig_cnt <= trig_cnt + 32'd1;
                  end
               end else if (trig_cnt >= MIN_W) begin
                  state    <= DELAY;
                  // entry happens one cycle after trig_s first reads 0
                  cnt      <= BURST_W - 32'd1;
                  echo_len <= (width_reg == '0) ? TIMEOUT_W : width_reg;
               end else begin
                  state <= IDLE;
               end
            end
            DELAY: begin
               if (cnt <= 32'd1) begin
                  state <= ECHO;
                  echo  <= 1'b1;
                  cnt   <= echo_len;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            ECHO: begin
               if (cnt <= 32'd1) begin
                  state       <= HOLDOFF;
                  echo        <= 1'b0;
                  pulse_count <= pulse_count + 16'd1;
                  cnt         <= HOLDOFF_W;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            HOLDOFF: begin
               echo <= 1'b0;
               if (cnt <= 32'd1) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            default: begin
               state <= IDLE;
               echo  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign read_data = {busy, 15'b0, pulse_count};

endmodule
